// File: rtl/regfile_sequencer_pkg.sv
// Shared opcodes and FSM encoding for the register-file sequencer.
package regfile_sequencer_pkg;

    localparam logic [2:0] OP_ADD  = 3'd0;
    localparam logic [2:0] OP_SUB  = 3'd1;
    localparam logic [2:0] OP_AND  = 3'd2;
    localparam logic [2:0] OP_OR   = 3'd3;
    localparam logic [2:0] OP_XOR  = 3'd4;
    localparam logic [2:0] OP_SLTU = 3'd5;
    localparam logic [2:0] OP_MOV  = 3'd6;
    localparam logic [2:0] OP_LDI  = 3'd7;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_EXEC  = 2'd2,
        ST_WRITE = 2'd3
    } state_t;

endpackage

// File: rtl/regfile_sequencer_if.sv
// Instruction issue handshake between an issuer and the sequencer.
interface regfile_sequencer_if #(
    parameter int WIDTH         = 4,
    parameter int ADDRESS_WIDTH = 2
);

    logic                     instr_valid;
    logic                     instr_ready;
    logic [2:0]               instr_op;
    logic [ADDRESS_WIDTH-1:0] instr_rd;
    logic [ADDRESS_WIDTH-1:0] instr_rs0;
    logic [ADDRESS_WIDTH-1:0] instr_rs1;
    logic [WIDTH-1:0]         instr_imm;

    modport master (
        output instr_valid,
        output instr_op,
        output instr_rd,
        output instr_rs0,
        output instr_rs1,
        output instr_imm,
        input  instr_ready
    );

    modport slave (
        input  instr_valid,
        input  instr_op,
        input  instr_rd,
        input  instr_rs0,
        input  instr_rs1,
        input  instr_imm,
        output instr_ready
    );

endinterface

// File: rtl/regfile_sequencer_alu.sv
// Combinational ALU; all results wrap modulo 2^WIDTH.
module sequencer_alu
    import regfile_sequencer_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic [2:0]       op_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic [WIDTH-1:0] imm_i,
    output logic [WIDTH-1:0] result_o
);

    always_comb begin
        result_o = '0;
        case (op_i)
            OP_ADD:  result_o = a_i + b_i;
            OP_SUB:  result_o = a_i - b_i;
            OP_AND:  result_o = a_i & b_i;
            OP_OR:   result_o = a_i | b_i;
            OP_XOR:  result_o = a_i ^ b_i;
            OP_SLTU: result_o = WIDTH'(a_i < b_i);
            OP_MOV:  result_o = a_i;
            OP_LDI:  result_o = imm_i;
            default: result_o = '0;
        endcase
    end

endmodule

// File: rtl/regfile_sequencer.sv
// Four-cycle issue/read/exec/write controller in front of a 1W2R register file.
module regfile_sequencer
    import regfile_sequencer_pkg::*;
#(
    parameter int WIDTH         = 4,
    parameter int ADDRESS_WIDTH = 2
) (
    input  logic                     clock,
    input  logic                     reset_n,
    regfile_sequencer_if.slave       instr,
    output logic [ADDRESS_WIDTH-1:0] a0,
    output logic [ADDRESS_WIDTH-1:0] a1,
    input  logic [WIDTH-1:0]         rd0,
    input  logic [WIDTH-1:0]         rd1,
    output logic                     we,
    output logic [ADDRESS_WIDTH-1:0] a2,
    output logic [WIDTH-1:0]         wd,
    output logic                     busy,
    output logic                     done
);

    state_t state_q, state_d;

    logic [2:0]               op_q;
    logic [ADDRESS_WIDTH-1:0] rd_q, rs0_q, rs1_q;
    logic [WIDTH-1:0]         imm_q;
    logic [WIDTH-1:0]         opa_q, opb_q;
    logic [WIDTH-1:0]         result_q;
    logic [WIDTH-1:0]         alu_res;
    logic                     ready;
    logic                     accept;

    assign accept = instr.instr_valid && ready;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:  if (accept) state_d = ST_READ;
            ST_READ:  state_d = ST_EXEC;
            ST_EXEC:  state_d = ST_WRITE;
            ST_WRITE: state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Strobes decode from state alone so reset kills them at once.
    always_comb begin
        ready = (state_q == ST_IDLE);
        busy  = !ready;
        done  = (state_q == ST_WRITE);
        we    = (state_q == ST_WRITE) && (rd_q != '0);
    end

    assign instr.instr_ready = ready;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            op_q     <= '0;
            rd_q     <= '0;
            rs0_q    <= '0;
            rs1_q    <= '0;
            imm_q    <= '0;
            opa_q    <= '0;
            opb_q    <= '0;
            result_q <= '0;
        end else begin
            if (accept) begin
                op_q  <= instr.instr_op;
                rd_q  <= instr.instr_rd;
                rs0_q <= instr.instr_rs0;
                rs1_q <= instr.instr_rs1;
                imm_q <= instr.instr_imm;
            end
            if (state_q == ST_READ) begin
                opa_q <= rd0;
                opb_q <= rd1;
            end
            if (state_q == ST_EXEC) begin
                result_q <= alu_res;
            end
        end
    end

    sequencer_alu #(.WIDTH(WIDTH)) u_alu (
        .op_i     (op_q),
        .a_i      (opa_q),
        .b_i      (opb_q),
        .imm_i    (imm_q),
        .result_o (alu_res)
    );

    assign a0 = rs0_q;
    assign a1 = rs1_q;
    assign a2 = rd_q;
    assign wd = result_q;

endmodule

// File: tb/tb_regfile_sequencer.sv
// Bench for regfile_sequencer with a behavioural register file and model.
module tb_regfile_sequencer;
    import regfile_sequencer_pkg::*;

    localparam int W    = 4;
    localparam int AW   = 2;
    localparam int MASK = (1 << W) - 1;

    logic clock   = 1'b0;
    logic reset_n = 1'b1;
    always #5 clock = ~clock;

    regfile_sequencer_if #(.WIDTH(W), .ADDRESS_WIDTH(AW)) bus ();

    logic [AW-1:0] a0, a1, a2;
    logic [W-1:0]  rd0, rd1, wd;
    logic          we, busy, done;

    regfile_sequencer #(.WIDTH(W), .ADDRESS_WIDTH(AW)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .instr   (bus),
        .a0      (a0),
        .a1      (a1),
        .rd0     (rd0),
        .rd1     (rd1),
        .we      (we),
        .a2      (a2),
        .wd      (wd),
        .busy    (busy),
        .done    (done)
    );

    // Register file under the sequencer; r0 reads as zero.
    logic [W-1:0] rf [4];
    logic         rf_clear;
    always @(posedge clock) begin
        if (rf_clear) begin
            for (int k = 0; k < 4; k++) rf[k] <= '0;
        end else if (we) begin
            rf[a2] <= wd;
        end
    end
    assign rd0 = (a0 == '0) ? '0 : rf[a0];
    assign rd1 = (a1 == '0) ? '0 : rf[a1];

    int vectors     = 0;
    int miscompares = 0;
    int mdl [4];

    function automatic int ref_alu(int op, int a, int b, int imm);
        int r;
        case (op)
            0: r = a + b;
            1: r = a - b;
            2: r = a & b;
            3: r = a | b;
            4: r = a ^ b;
            5: r = (a < b) ? 1 : 0;
            6: r = a;
            default: r = imm;
        endcase
        return r & MASK;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic scramble();
        bus.instr_op  = 3'($urandom);
        bus.instr_rd  = AW'($urandom);
        bus.instr_rs0 = AW'($urandom);
        bus.instr_rs1 = AW'($urandom);
        bus.instr_imm = W'($urandom);
    endtask

    // Issue one instruction from an idle negedge; returns at the next idle negedge.
    task automatic run(input int op, input int rd, input int rs0,
                       input int rs1, input int imm);
        int exp;
        chk("pre_ready", bus.instr_ready, 1);
        bus.instr_valid = 1'b1;
        bus.instr_op    = 3'(op);
        bus.instr_rd    = AW'(rd);
        bus.instr_rs0   = AW'(rs0);
        bus.instr_rs1   = AW'(rs1);
        bus.instr_imm   = W'(imm);
        @(posedge clock);
        #1;
        bus.instr_valid = 1'b0;
        scramble();
        @(negedge clock);
        chk("read_a0", a0, rs0);
        chk("read_a1", a1, rs1);
        chk("read_busy", busy, 1);
        chk("read_ready", bus.instr_ready, 0);
        exp = ref_alu(op, mdl[rs0], mdl[rs1], imm);
        @(negedge clock);
        chk("exec_we", we, 0);
        chk("exec_done", done, 0);
        @(negedge clock);
        chk("wr_done", done, 1);
        chk("wr_we", we, (rd != 0) ? 1 : 0);
        chk("wr_a2", a2, rd);
        chk("wr_wd", wd, exp);
        if (rd != 0) mdl[rd] = exp;
        @(negedge clock);
        chk("post_ready", bus.instr_ready, 1);
        chk("post_done", done, 0);
        if (rd != 0) chk("rf_commit", rf[rd], mdl[rd]);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        int acc_op, acc_rd, acc_rs0, acc_rs1, acc_imm, exp;
        for (int k = 0; k < 4; k++) mdl[k] = 0;
        rf_clear        = 1'b1;
        bus.instr_valid = 1'b0;
        bus.instr_op    = '0;
        bus.instr_rd    = '0;
        bus.instr_rs0   = '0;
        bus.instr_rs1   = '0;
        bus.instr_imm   = '0;

        #3 reset_n = 1'b0;
        #1;
        chk("rst_ready", bus.instr_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_we", we, 0);
        chk("rst_done", done, 0);
        chk("rst_a2", a2, 0);
        chk("rst_wd", wd, 0);
        chk("rst_a0", a0, 0);
        chk("rst_a1", a1, 0);
        repeat (2) @(negedge clock);
        rf_clear = 1'b0;
        reset_n  = 1'b1;
        @(negedge clock);
        chk("idle_busy", busy, 0);

        run(7, 1, 0, 0, 5);
        chk("ldi_r1", rf[1], 5);
        run(7, 2, 0, 0, 3);
        run(0, 3, 1, 2, 0);
        chk("add_r3", rf[3], 8);
        run(1, 3, 2, 1, 0);
        chk("sub_r3", rf[3], 4'hE);
        run(5, 3, 2, 1, 0);
        chk("sltu_lt", rf[3], 1);
        run(5, 3, 1, 2, 0);
        chk("sltu_ge", rf[3], 0);
        run(0, 0, 1, 2, 0);
        run(6, 3, 0, 0, 0);
        chk("r0_zero", rf[3], 0);
        run(2, 3, 1, 2, 0);
        run(3, 3, 1, 2, 0);
        run(4, 3, 1, 2, 0);

        // Valid held high with fields changing every cycle.
        for (int i = 0; i < 16; i++) begin
            case (i % 4)
                0: begin
                    chk("hold_ready", bus.instr_ready, 1);
                    bus.instr_valid = 1'b1;
                    scramble();
                    acc_op  = bus.instr_op;
                    acc_rd  = bus.instr_rd;
                    acc_rs0 = bus.instr_rs0;
                    acc_rs1 = bus.instr_rs1;
                    acc_imm = bus.instr_imm;
                end
                1: begin
                    chk("hold_a0", a0, acc_rs0);
                    chk("hold_a1", a1, acc_rs1);
                    chk("hold_busy", busy, 1);
                    scramble();
                end
                2: begin
                    chk("hold_exec_we", we, 0);
                    scramble();
                end
                default: begin
                    exp = ref_alu(acc_op, mdl[acc_rs0], mdl[acc_rs1], acc_imm);
                    chk("hold_done", done, 1);
                    chk("hold_we", we, (acc_rd != 0) ? 1 : 0);
                    chk("hold_a2", a2, acc_rd);
                    chk("hold_wd", wd, exp);
                    if (acc_rd != 0) mdl[acc_rd] = exp;
                    scramble();
                end
            endcase
            @(negedge clock);
        end
        bus.instr_valid = 1'b0;
        chk("hold_end_ready", bus.instr_ready, 1);

        // Reset during EXEC aborts without a write.
        run(7, 3, 0, 0, 9);
        run(7, 1, 0, 0, 2);
        run(7, 2, 0, 0, 4);
        bus.instr_valid = 1'b1;
        bus.instr_op    = 3'(OP_ADD);
        bus.instr_rd    = 2'd3;
        bus.instr_rs0   = 2'd1;
        bus.instr_rs1   = 2'd2;
        @(posedge clock);
        #1 bus.instr_valid = 1'b0;
        @(negedge clock);
        @(negedge clock);
        #2 reset_n = 1'b0;
        #1;
        chk("abort_ready", bus.instr_ready, 1);
        chk("abort_busy", busy, 0);
        chk("abort_we", we, 0);
        chk("abort_done", done, 0);
        chk("abort_a2", a2, 0);
        chk("abort_wd", wd, 0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            chk("abort_no_we", we, 0);
        end
        chk("abort_r3_kept", rf[3], 9);
        reset_n = 1'b1;
        @(negedge clock);
        chk("abort_idle", bus.instr_ready, 1);
        run(6, 1, 3, 0, 0);
        chk("abort_read_r3", rf[1], 9);

        for (int i = 0; i < 24; i++) begin
            run($urandom_range(0, 7), $urandom_range(0, 3),
                $urandom_range(0, 3), $urandom_range(0, 3),
                $urandom_range(0, MASK));
        end

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
